// File: rtl/cla_nibble_serial_adder.sv
// ----------------------------------------------------------------------------
// cla_nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit CLA per cycle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cla_4_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       p,
  output logic       g
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g    = a & b;
  assign w_p    = a ^ b;
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign s    = w_p ^ w_c[3:0];
  assign cout = w_c[4];
  assign p    = &w_p;
  assign g    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  generate
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
      $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [3:0] cla_a;
  logic [3:0] cla_b;
  logic [3:0] cla_s;
  logic       cla_cout;

  always_comb begin
    cla_a = '0;
    cla_b = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDXW'(k)) begin
        cla_a = a_sh_q[4*k +: 4];
        cla_b = b_sh_q[4*k +: 4];
      end
    end
  end

  cla_4_bit_adder u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry_q),
    .s    (cla_s),
    .cout (cla_cout),
    .p    (),
    .g    ()
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = (state_q == IDLE) && rst_n;
    out_valid = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < N; k++) begin
          if (idx_q == IDXW'(k)) begin
            sum_d[4*k +: 4] = cla_s;
          end
        end
        carry_d = cla_cout;
        if (idx_q == LAST_IDX) begin
          // Carry into the MSB recovered from its sum bit: c = s ^ a ^ b.
          cout_d  = cla_cout;
          ovf_d   = cla_cout ^ (a_sh_q[WIDTH-1] ^ b_sh_q[WIDTH-1] ^ cla_s[3]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_cla_nibble_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_cla_nibble_serial_adder: random and directed checks of WIDTH 4/8/16 adders
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cla_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a_drv, b_drv;
  logic        cin_drv, in_valid_drv, out_ready;
  int          sel;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  logic iv4, iv8, iv16;
  logic ir4, ir8, ir16, ov4, ov8, ov16;
  logic co4, co8, co16, of4, of8, of16;
  logic [3:0]  s4;
  logic [7:0]  s8;
  logic [15:0] s16;

  assign iv4  = in_valid_drv && (sel == 4);
  assign iv8  = in_valid_drv && (sel == 8);
  assign iv16 = in_valid_drv && (sel == 16);

  cla_nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a_drv[3:0]), .b(b_drv[3:0]), .cin(cin_drv), .out_valid(ov4),
    .out_ready(out_ready), .sum(s4), .cout(co4), .ovf(of4));

  cla_nibble_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin_drv), .out_valid(ov8),
    .out_ready(out_ready), .sum(s8), .cout(co8), .ovf(of8));

  cla_nibble_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a_drv), .b(b_drv), .cin(cin_drv), .out_valid(ov16),
    .out_ready(out_ready), .sum(s16), .cout(co16), .ovf(of16));

  logic        m_ir, m_ov, m_co, m_of;
  logic [15:0] m_sum;

  always_comb begin
    m_ir = ir16; m_ov = ov16; m_co = co16; m_of = of16; m_sum = s16;
    if (sel == 4) begin
      m_ir = ir4; m_ov = ov4; m_co = co4; m_of = of4; m_sum = {12'b0, s4};
    end else if (sel == 8) begin
      m_ir = ir8; m_ov = ov8; m_co = co8; m_of = of8; m_sum = {8'b0, s8};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (w=%0d t=%0t)", tag, obs, exp, sel, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow from the signed range.
  task automatic ref_add(input int w, input logic [15:0] a, input logic [15:0] b, input logic cin,
                         output logic [15:0] s, output logic co, output logic ov);
    longint ua, ub, tot, sa, sb, ssum, span;
    span = longint'(1) << w;
    ua   = longint'(a) % span;
    ub   = longint'(b) % span;
    tot  = ua + ub + longint'(cin);
    s    = 16'(tot % span);
    co   = (tot >= span);
    sa   = (ua >= span / 2) ? ua - span : ua;
    sb   = (ub >= span / 2) ? ub - span : ub;
    ssum = sa + sb + longint'(cin);
    ov   = (ssum > span / 2 - 1) || (ssum < -(span / 2));
  endtask

  task automatic do_add(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input int hold);
    logic [15:0] es;
    logic        eco, eov;
    int          lat;
    ref_add(w, a, b, cin, es, eco, eov);
    @(negedge clk);
    sel = w;
    #1;
    check_eq("in_ready_idle", 32'(m_ir), 32'd1);
    a_drv = a; b_drv = b; cin_drv = cin; in_valid_drv = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid_drv = 1'b0;
    a_drv = 16'($urandom); b_drv = 16'($urandom); cin_drv = 1'($urandom);
    check_eq("in_ready_busy", 32'(m_ir), 32'd0);
    lat = 0;
    while (!m_ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(w / 4));
    for (int i = 0; i < hold; i++) begin
      in_valid_drv = 1'($urandom);
      a_drv = 16'($urandom); b_drv = 16'($urandom);
      @(negedge clk);
      check_eq("hold_sum", 32'(m_sum), 32'(es));
      check_eq("hold_flags", {29'b0, m_ov, m_co, m_of}, {29'b0, 1'b1, eco, eov});
      check_eq("hold_in_ready", 32'(m_ir), 32'd0);
      @(posedge clk); #1;
    end
    in_valid_drv = 1'b0;
    out_ready    = 1'b1;
    @(negedge clk);
    check_eq("sum", 32'(m_sum), 32'(es));
    check_eq("cout", 32'(m_co), 32'(eco));
    check_eq("ovf", 32'(m_of), 32'(eov));
    check_eq("out_valid", 32'(m_ov), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("out_valid_drop", 32'(m_ov), 32'd0);
    check_eq("in_ready_after", 32'(m_ir), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; sel = 16; a_drv = '0; b_drv = '0; cin_drv = 1'b0;
    in_valid_drv = 1'b0; out_ready = 1'b0;
    #22;
    check_eq("rst_sum", 32'(m_sum), 32'd0);
    check_eq("rst_flags", {29'b0, m_ov, m_co, m_of}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(m_ir), 32'd1);

    do_add(16, 16'h1234, 16'h4321, 1'b0, 0);
    do_add(16, 16'hFFFF, 16'h0000, 1'b1, 1);
    do_add(16, 16'h7FFF, 16'h0001, 1'b0, 0);
    do_add(16, 16'h8000, 16'h8000, 1'b0, 2);
    do_add(16, 16'hA5A5, 16'h5A5A, 1'b1, 10);

    // Abort in the second RUN cycle; no result may surface afterwards.
    @(negedge clk);
    sel = 16; a_drv = 16'h1111; b_drv = 16'h2222; cin_drv = 1'b0; in_valid_drv = 1'b1;
    @(posedge clk); #1;
    in_valid_drv = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", 32'(m_ov), 32'd0);
    check_eq("abort_sum", 32'(m_sum), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("abort_no_result", 32'(m_ov), 32'd0);
    end
    do_add(16, 16'h00FF, 16'h0001, 1'b0, 0);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int c = 0; c < 2; c++)
          do_add(4, 16'(i), 16'(j), 1'(c), int'($urandom_range(0, 2)));
    for (int i = 0; i < 400; i++)
      do_add(8, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    for (int i = 0; i < 200; i++)
      do_add(16, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
